// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver: parity modes, FSM states
// and the baud divider calculation.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Clock cycles per bit on the line.
  function automatic int unsigned calc_baud_div(input int unsigned clock_freq,
                                                input int unsigned baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer (preset to idle-high) plus a falling-edge detector.
// The detector stays disarmed until the pipeline holds real line samples.
module uart_rx_sync (
  input  logic i_sysclk,
  input  logic i_sysrst,
  input  logic i_uart_rx,
  output logic rx_line,
  output logic rx_fall_c
);

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       prev_q;

  // prev_q only becomes 1 from a genuine high sample, so a line held low
  // through reset release never looks like a 1->0 edge.
  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      sync_q <= 2'b11;
      fill_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_uart_rx};
      fill_q <= {fill_q[0], 1'b1};
      prev_q <= sync_q[1] & fill_q[1];
    end
  end

  assign rx_line   = sync_q[1];
  assign rx_fall_c = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame receiver: majority-voted mid-bit sampling, optional parity,
// one or two stop bits, frame/break detection and a one-cycle valid pulse.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 i_sysclk,
  input  logic                 i_sysrst,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int unsigned BAUD_DIV = calc_baud_div(CLOCK_FREQ, BAUD);
  localparam int unsigned MID      = (BAUD_DIV - 1) / 2;
  localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W    = 4;
  localparam logic        ODD_PAR  = (PARITY == PAR_ODD);
  localparam logic        HAS_PAR  = (PARITY != PAR_NONE);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_frame_rx: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_frame_rx: STOP_BITS must be 1 or 2");
  end
  if (BAUD_DIV < 8) begin : g_bad_baud_div
    $error("uart_frame_rx: CLOCK_FREQ/BAUD must be >= 8");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_frame_rx: PARITY must be 0, 1 or 2");
  end

  logic rx_line;
  logic rx_fall_c;

  uart_rx_sync u_sync (
    .i_sysclk  (i_sysclk),
    .i_sysrst  (i_sysrst),
    .i_uart_rx (i_uart_rx),
    .rx_line   (rx_line),
    .rx_fall_c (rx_fall_c)
  );

  rx_state_e            state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [BIT_W-1:0]     bit_q, bit_n;
  logic                 s0_q, s0_n;
  logic                 s1_q, s1_n;
  logic [DATA_BITS-1:0] shreg_q, shreg_n;
  logic                 par_err_q, par_err_n;
  logic                 frm_err_q, frm_err_n;
  logic                 zero_q, zero_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, pe_n, fe_n, brk_n, busy_n;

  logic at_m1_c, at_mid_c, at_vote_c, at_wrap_c, vote_c, last_stop_c, stop_bad_c;

  assign at_m1_c     = (cnt_q == CNT_W'(MID - 1));
  assign at_mid_c    = (cnt_q == CNT_W'(MID));
  assign at_vote_c   = (cnt_q == CNT_W'(MID + 1));
  assign at_wrap_c   = (cnt_q == CNT_W'(BAUD_DIV - 1));
  assign vote_c      = (s0_q & s1_q) | (s0_q & rx_line) | (s1_q & rx_line);
  assign last_stop_c = (bit_q == BIT_W'(STOP_BITS - 1));
  assign stop_bad_c  = frm_err_q | ~vote_c;

  // Next-state and datapath logic; the final stop bit ends the frame at its
  // vote point rather than at its end so the next start edge is not missed.
  always_comb begin
    state_n   = state_q;
    cnt_n     = at_wrap_c ? '0 : cnt_q + 1'b1;
    bit_n     = bit_q;
    s0_n      = at_m1_c  ? rx_line : s0_q;
    s1_n      = at_mid_c ? rx_line : s1_q;
    shreg_n   = shreg_q;
    par_err_n = par_err_q;
    frm_err_n = frm_err_q;
    zero_n    = zero_q;
    data_n    = o_rx_data;
    valid_n   = 1'b0;
    pe_n      = o_parity_err;
    fe_n      = o_frame_err;
    brk_n     = o_break;

    case (state_q)
      ST_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (rx_fall_c) begin
          state_n   = ST_START;
          par_err_n = 1'b0;
          frm_err_n = 1'b0;
          zero_n    = 1'b1;
        end
      end

      ST_START: begin
        if (at_vote_c && vote_c) begin
          state_n = ST_IDLE;
        end else if (at_wrap_c) begin
          state_n = ST_DATA;
        end
      end

      ST_DATA: begin
        if (at_vote_c) begin
          shreg_n = {vote_c, shreg_q[DATA_BITS-1:1]};
          if (vote_c) zero_n = 1'b0;
        end
        if (at_wrap_c) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (at_vote_c) begin
          par_err_n = (^{shreg_q, vote_c}) ^ ODD_PAR;
          if (vote_c) zero_n = 1'b0;
        end
        if (at_wrap_c) state_n = ST_STOP;
      end

      ST_STOP: begin
        if (at_vote_c) begin
          if (last_stop_c) begin
            data_n  = shreg_q;
            valid_n = 1'b1;
            pe_n    = par_err_q;
            fe_n    = stop_bad_c;
            brk_n   = zero_q & ~vote_c;
            state_n = stop_bad_c ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            if (!vote_c) frm_err_n = 1'b1;
            if (vote_c)  zero_n    = 1'b0;
          end
        end else if (at_wrap_c) begin
          bit_n = bit_q + 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_line) state_n = ST_IDLE;
      end

      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      shreg_q      <= '0;
      par_err_q    <= 1'b0;
      frm_err_q    <= 1'b0;
      zero_q       <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      bit_q        <= bit_n;
      s0_q         <= s0_n;
      s1_q         <= s1_n;
      shreg_q      <= shreg_n;
      par_err_q    <= par_err_n;
      frm_err_q    <= frm_err_n;
      zero_q       <= zero_n;
      o_rx_data    <= data_n;
      o_rx_valid   <= valid_n;
      o_parity_err <= pe_n;
      o_frame_err  <= fe_n;
      o_break      <= brk_n;
      o_busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: three configurations (8N1, 7E1, 8N2) driven with
// directed frames; a frame-level model predicts every valid pulse.
module tb_uart_frame_rx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int          DIV    = 10;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

  logic [7:0] d0; logic v0, pe0, fe0, bk0, by0;
  logic [6:0] d1; logic v1, pe1, fe1, bk1, by1;
  logic [7:0] d2; logic v2, pe2, fe2, bk2, by2;

  always #5 clk = ~clk;

  uart_frame_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .i_sysclk(clk), .i_sysrst(rst), .i_uart_rx(rx0), .o_rx_data(d0), .o_rx_valid(v0),
    .o_parity_err(pe0), .o_frame_err(fe0), .o_break(bk0), .o_busy(by0));

  uart_frame_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .i_sysclk(clk), .i_sysrst(rst), .i_uart_rx(rx1), .o_rx_data(d1), .o_rx_valid(v1),
    .o_parity_err(pe1), .o_frame_err(fe1), .o_break(bk1), .o_busy(by1));

  uart_frame_rx #(.CLOCK_FREQ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut2 (
    .i_sysclk(clk), .i_sysrst(rst), .i_uart_rx(rx2), .o_rx_data(d2), .o_rx_valid(v2),
    .o_parity_err(pe2), .o_frame_err(fe2), .o_break(bk2), .o_busy(by2));

  int cfg_db  [3] = '{8, 7, 8};
  int cfg_par [3] = '{0, 2, 0};
  int cfg_sb  [3] = '{1, 1, 2};

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$], q1[$], q2[$];
  exp_t last [3];
  int   vcnt [3] = '{0, 0, 0};

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Frame-level prediction from the bit values placed on the line.
  task automatic push_exp(input int w, input logic [8:0] data, input logic par_bit,
                          input logic [1:0] stops);
    exp_t e;
    logic [8:0] dm;
    logic allz;
    dm = '0;
    for (int b = 0; b < 9; b++) if (b < cfg_db[w]) dm[b] = data[b];
    e.data = dm;
    e.pe   = (cfg_par[w] != 0) && (((^dm) ^ par_bit) != (cfg_par[w] == 1));
    e.fe   = 1'b0;
    allz   = (dm == 9'd0) && (cfg_par[w] == 0 || par_bit == 1'b0);
    for (int s = 0; s < cfg_sb[w]; s++) begin
      if (stops[s]) allz = 1'b0;
      else e.fe = 1'b1;
    end
    e.brk = allz;
    case (w)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic cmp_dut(input int i, input logic v, input logic [8:0] d, input logic pe,
                         input logic fe, input logic bk, input logic by);
    exp_t e;
    logic have;
    if (rst) begin
      chk($sformatf("rst_data%0d", i), d, 9'd0);
      chk($sformatf("rst_ctl%0d", i), {4'd0, v, pe, fe, bk, by}, 9'd0);
      last[i] = '0;
      case (i)
        0: q0.delete();
        1: q1.delete();
        default: q2.delete();
      endcase
    end else begin
      if (v) begin
        vcnt[i]++;
        have = 1'b0;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL unexpected_valid%0d actual=1 required=0 @%0t", i, $time);
        end else begin
          last[i] = e;
        end
      end
      chk($sformatf("data%0d", i), d, last[i].data);
      chk($sformatf("flags%0d", i), {6'd0, pe, fe, bk}, {6'd0, last[i].pe, last[i].fe, last[i].brk});
    end
  endtask

  always @(negedge clk) begin
    cmp_dut(0, v0, {1'b0, d0}, pe0, fe0, bk0, by0);
    cmp_dut(1, v1, {2'b0, d1}, pe1, fe1, bk1, by1);
    cmp_dut(2, v2, {1'b0, d2}, pe2, fe2, bk2, by2);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic v);
    case (w)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send_frame(input int w, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stops);
    push_exp(w, data, par_bit, stops);
    drive(w, 1'b0); wait_cyc(DIV);
    for (int b = 0; b < cfg_db[w]; b++) begin drive(w, data[b]); wait_cyc(DIV); end
    if (cfg_par[w] != 0) begin drive(w, par_bit); wait_cyc(DIV); end
    for (int s = 0; s < cfg_sb[w]; s++) begin drive(w, stops[s]); wait_cyc(DIV); end
    drive(w, 1'b1); wait_cyc(3 * DIV);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int   base;
    logic saw;
    int   fell;

    wait_cyc(3);
    chk("reset_busy", {8'd0, by0}, 9'd0);
    chk("reset_data", {1'b0, d0}, 9'd0);
    rst = 1'b0;
    wait_cyc(5);
    chk("idle_busy", {8'd0, by0}, 9'd0);

    // 8N1 0xA5
    base = vcnt[0];
    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    chk("a5_pulses", 9'(vcnt[0] - base), 9'd1);
    chk("a5_data", {1'b0, d0}, 9'h0A5);
    chk("a5_flags", {6'd0, pe0, fe0, bk0}, 9'd0);

    // Further 8N1 patterns, including a stop-low all-zero frame (break)
    send_frame(0, 9'h000, 1'b0, 2'b11);
    chk("zero_brk", {8'd0, bk0}, 9'd0);
    send_frame(0, 9'h0FF, 1'b0, 2'b11);
    send_frame(0, 9'h05A, 1'b0, 2'b00);
    chk("5a_stop_low_fe", {7'd0, fe0, bk0}, 9'b10);
    send_frame(0, 9'h000, 1'b0, 2'b00);
    chk("short_break", {7'd0, fe0, bk0}, 9'b11);

    // 7E1: 0x53 has four ones, so parity bit 1 is wrong for even mode
    send_frame(1, 9'h053, 1'b1, 2'b11);
    chk("53_par1_pe", {8'd0, pe1}, 9'd1);
    chk("53_par1_data", {2'b0, d1}, 9'h053);
    send_frame(1, 9'h053, 1'b0, 2'b11);
    chk("53_par0_pe", {8'd0, pe1}, 9'd0);
    send_frame(1, 9'h07F, 1'b0, 2'b11);
    send_frame(1, 9'h07F, 1'b1, 2'b11);

    // Short low glitch on an idle line
    base = vcnt[0];
    drive(0, 1'b0); wait_cyc(3); drive(0, 1'b1);
    saw  = 1'b0;
    fell = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (by0) saw = 1'b1;
      else if (saw && fell < 0) fell = k;
    end
    chk("glitch_busy_seen", {8'd0, saw}, 9'd1);
    chk("glitch_busy_clear", {8'd0, fell >= 0}, 9'd1);
    wait_cyc(2 * DIV);
    chk("glitch_no_pulse", 9'(vcnt[0] - base), 9'd0);

    // 8N2: second stop bit low, then a clean frame
    send_frame(2, 9'h03C, 1'b0, 2'b01);
    chk("3c_fe_brk", {7'd0, fe2, bk2}, 9'b10);
    chk("3c_data", {1'b0, d2}, 9'h03C);
    send_frame(2, 9'h081, 1'b0, 2'b11);
    chk("81_data", {1'b0, d2}, 9'h081);
    chk("81_flags", {6'd0, pe2, fe2, bk2}, 9'd0);

    // Line held low for 30 bit times
    base = vcnt[0];
    push_exp(0, 9'h000, 1'b0, 2'b00);
    drive(0, 1'b0);
    wait_cyc(30 * DIV);
    chk("break_pulses", 9'(vcnt[0] - base), 9'd1);
    chk("break_flags", {6'd0, pe0, fe0, bk0}, 9'b011);
    chk("break_data", {1'b0, d0}, 9'd0);
    drive(0, 1'b1);
    wait_cyc(3 * DIV);
    chk("break_after_high", 9'(vcnt[0] - base), 9'd1);

    // Reset during bit 4 of 0xFF
    base = vcnt[0];
    drive(0, 1'b0); wait_cyc(DIV);
    drive(0, 1'b1); wait_cyc(4 * DIV + DIV / 2);
    chk("midframe_busy", {8'd0, by0}, 9'd1);
    rst = 1'b1;
    wait_cyc(2);
    chk("rst_mid_outs", {3'd0, v0, pe0, fe0, bk0, by0, 1'b0}, 9'd0);
    chk("rst_mid_data0", {1'b0, d0}, 9'd0);
    chk("rst_mid_data2", {1'b0, d2}, 9'd0);
    rst = 1'b0;
    wait_cyc(8 * DIV);
    chk("rst_no_pulse", 9'(vcnt[0] - base), 9'd0);
    send_frame(0, 9'h012, 1'b0, 2'b11);
    chk("12_data", {1'b0, d0}, 9'h012);
    chk("12_pulses", 9'(vcnt[0] - base), 9'd1);

    chk("q0_drained", 9'(q0.size()), 9'd0);
    chk("q1_drained", 9'(q1.size()), 9'd0);
    chk("q2_drained", 9'(q2.size()), 9'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
